// File: rtl/cpu_ctrl.sv
// Six-T-state fetch/execute sequencer for the 8-bit CPU; strobes are a Moore decode of state and ir_op.
// Optional CARRY_JMP_EN macro enables opcode 0011 as JC (jump on carry).
module cpu_ctrl #(
  parameter int T_STATES = 6,
  parameter int OP_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_run,
  input  logic [OP_W-1:0] ir_op,
  input  logic            alu_cy,
  output logic            pc_inc,
  output logic            pc_out,
  output logic            pc_load,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            alu_out,
  output logic            alu_cut,
  output logic            out_load,
  output logic            cy_flag,
  output logic            halt,
  output logic [2:0]      t_state
);

  if (T_STATES != 6) begin : g_bad_t_states
    $error("cpu_ctrl supports only T_STATES == 6");
  end

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);
`ifdef CARRY_JMP_EN
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(3);
`endif

  state_t state;
  logic   active;
  logic   is_arith;

  assign is_arith = (ir_op == OP_ADD) || (ir_op == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_T1;
      cy_flag <= 1'b0;
    end else if (ctrl_run && state != S_HALT) begin
      if (state == S_T6 && is_arith) cy_flag <= alu_cy;
      case (state)
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= (ir_op == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        default: state <= S_HALT;
      endcase
    end
  end

  assign halt    = (state == S_HALT);
  assign t_state = state;

  // Strobes are suppressed whenever the sequencer is not advancing, so a pause or reset never issues a partial step.
  assign active = !rst && ctrl_run && (state != S_HALT);

  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    alu_cut  = 1'b0;
    out_load = 1'b0;
`ifdef CARRY_JMP_EN
    pc_load  = 1'b0;
`endif
    if (active) begin
      case (state)
        S_T1: begin pc_out = 1'b1; mar_load = 1'b1; end
        S_T2: pc_inc = 1'b1;
        S_T3: begin ram_out = 1'b1; ir_load = 1'b1; end
        S_T4: begin
          if (ir_op == OP_LDA || is_arith) begin
            ir_out = 1'b1; mar_load = 1'b1;
          end else if (ir_op == OP_OUT) begin
            a_out = 1'b1; out_load = 1'b1;
          end
`ifdef CARRY_JMP_EN
          else if (ir_op == OP_JC && cy_flag) begin
            ir_out = 1'b1; pc_load = 1'b1;
          end
`endif
        end
        S_T5: begin
          if (ir_op == OP_LDA) begin
            ram_out = 1'b1; a_load = 1'b1;
          end else if (is_arith) begin
            ram_out = 1'b1; b_load = 1'b1;
            alu_cut = (ir_op == OP_SUB);
          end
        end
        S_T6: begin
          if (is_arith) begin
            alu_out = 1'b1; a_load = 1'b1;
            alu_cut = (ir_op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

`ifndef CARRY_JMP_EN
  assign pc_load = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: expected outputs are queued when inputs are driven, compared at the following negedge.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst, ctrl_run, alu_cy;
  logic [3:0] ir_op;
  logic pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_cut, out_load, cy_flag, halt;
  logic [2:0] t_state;

  always #5 clk = ~clk;

  cpu_ctrl #(.T_STATES(6), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .ctrl_run(ctrl_run), .ir_op(ir_op), .alu_cy(alu_cy),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_cut(alu_cut),
    .out_load(out_load), .cy_flag(cy_flag), .halt(halt), .t_state(t_state)
  );

  // Strobe vector bit positions
  localparam int B_PC_INC = 12, B_PC_OUT = 11, B_PC_LOAD = 10, B_MAR_LOAD = 9;
  localparam int B_RAM_OUT = 8, B_IR_LOAD = 7, B_IR_OUT = 6, B_A_LOAD = 5;
  localparam int B_A_OUT = 4, B_B_LOAD = 3, B_ALU_OUT = 2, B_ALU_CUT = 1, B_OUT_LOAD = 0;

  typedef struct packed {
    logic [12:0] strb;
    logic [2:0]  ts;
    logic        hlt;
    logic        cy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_ts = 1;
  logic m_halt = 1'b0;
  logic m_cy = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_strb(input int ts, input logic [3:0] op,
                                           input logic cyf, input logic run, input logic r);
    logic [12:0] s;
    s = '0;
    if (!r && run && ts != 0) begin
      case (ts)
        1: begin s[B_PC_OUT] = 1; s[B_MAR_LOAD] = 1; end
        2: s[B_PC_INC] = 1;
        3: begin s[B_RAM_OUT] = 1; s[B_IR_LOAD] = 1; end
        4: case (op)
             4'b0000, 4'b0001, 4'b0010: begin s[B_IR_OUT] = 1; s[B_MAR_LOAD] = 1; end
             4'b1110: begin s[B_A_OUT] = 1; s[B_OUT_LOAD] = 1; end
`ifdef CARRY_JMP_EN
             4'b0011: if (cyf) begin s[B_IR_OUT] = 1; s[B_PC_LOAD] = 1; end
`endif
             default: ;
           endcase
        5: case (op)
             4'b0000: begin s[B_RAM_OUT] = 1; s[B_A_LOAD] = 1; end
             4'b0001: begin s[B_RAM_OUT] = 1; s[B_B_LOAD] = 1; end
             4'b0010: begin s[B_RAM_OUT] = 1; s[B_B_LOAD] = 1; s[B_ALU_CUT] = 1; end
             default: ;
           endcase
        6: case (op)
             4'b0001: begin s[B_ALU_OUT] = 1; s[B_A_LOAD] = 1; end
             4'b0010: begin s[B_ALU_OUT] = 1; s[B_A_LOAD] = 1; s[B_ALU_CUT] = 1; end
             default: ;
           endcase
        default: ;
      endcase
    end
    return s;
  endfunction

  // One clock: drive inputs, queue expectation, compare at negedge, advance the model at posedge.
  task automatic step(input logic r, input logic run, input logic [3:0] op, input logic cy);
    exp_t e, got;
    logic [12:0] obs;
    rst = r; ctrl_run = run; ir_op = op; alu_cy = cy;
    e.strb = exp_strb(m_ts, op, m_cy, run, r);
    e.ts   = 3'(m_ts);
    e.hlt  = m_halt;
    e.cy   = m_cy;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_cut, out_load};
    check("strobes", 16'(obs), 16'(got.strb));
    check("t_state", 16'(t_state), 16'(got.ts));
    check("halt", 16'(halt), 16'(got.hlt));
    check("cy_flag", 16'(cy_flag), 16'(got.cy));
    check("bus_onehot0", 16'($onehot0({pc_out, ram_out, ir_out, a_out, alu_out})), 16'd1);
    @(posedge clk);
    if (r) begin
      m_ts = 1; m_halt = 0; m_cy = 0;
    end else if (run && !m_halt) begin
      if (m_ts == 6 && (op == 4'b0001 || op == 4'b0010)) m_cy = cy;
      if (m_ts == 4 && op == 4'b1111) begin
        m_halt = 1; m_ts = 0;
      end else begin
        m_ts = (m_ts == 6) ? 1 : m_ts + 1;
      end
    end
    #1;
  endtask

  // Opcode is only meaningful from T4, so T1..T3 see random garbage on ir_op.
  task automatic instr(input logic [3:0] op, input logic cy);
    for (int k = 0; k < 6; k++)
      step(1'b0, 1'b1, (k < 3) ? 4'($urandom_range(15)) : op, cy);
  endtask

  initial begin
    rst = 1'b1; ctrl_run = 1'b0; ir_op = 4'd0; alu_cy = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 4'd0, 1'b0);

    instr(4'b0000, 1'b0);          // LDA
    step(1'b0, 1'b1, 4'd0, 1'b0);  // back at T1
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'b0000, 1'b0);

    instr(4'b0010, 1'b1);          // SUB sets carry
    instr(4'b0001, 1'b0);          // ADD clears carry
    instr(4'b1110, 1'b1);          // OUT
    instr(4'b0101, 1'b1);          // NOP

    instr(4'b0001, 1'b1);          // carry=1 then JC
    instr(4'b0011, 1'b0);
    instr(4'b0010, 1'b0);          // carry=0 then JC
    instr(4'b0011, 1'b1);

    // Pause at T3 for 5 cycles
    step(1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)));
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b0000, 1'b0);

    // Reset during T5 of ADD with carry previously set
    instr(4'b0010, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b0001, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 1'b0);
    instr(4'b0001, 1'b1);

    // Halt, ignore ctrl_run for 20 cycles, then reset out
    instr(4'b1111, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    instr(4'b0000, 1'b0);

    if (sb.size() != 0) check("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
